// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the processor run controller: FSM states, halt codes
// and the default halt instruction word.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_INSTR   = 2'd1,
    HALT_PC_LOOP = 2'd2,
    HALT_BUDGET  = 2'd3
  } halt_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          HOLD_CNT_W        = 4;

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Program-load stream and instruction-memory write port of the run controller.
// The controller is the slave; the top level / bench is the master.
interface proc_run_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output ld_valid, ld_data,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/proc_run_ctrl_load.sv
// Load sequencer: word-address counter, registered instruction-memory write
// path and the word-count compare that ends the LOAD phase.
module load_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              start_up_n,
  input  logic              clear,      // accepted go: rewind and latch length
  input  logic              flush,      // abort: drop any pending write
  input  logic              active,     // controller is in LOAD
  input  logic [ADDR_W:0]   load_len,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              last
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   len_q;
  logic              accept;

  assign accept = active & ld_valid;
  assign last   = accept && ((word_cnt + (ADDR_W+1)'(1)) == len_q);

  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      wr_ptr     <= '0;
      word_cnt   <= '0;
      len_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else if (flush) begin
      imem_we <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      word_cnt <= '0;
      len_q    <= load_len;
      imem_we  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values;
      // imem_addr must get the old wr_ptr, not the incremented one.
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= wr_ptr;
        imem_wdata <= ld_data;
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        word_cnt   <= word_cnt + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: loads a program, holds then releases the processor, counts
// RUN cycles and stops on a halt word, a PC self-loop or the cycle budget.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          CYC_W     = 16,
  parameter int          HOLD_CYC  = 2,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                clk,
  input  logic                start_up_n,
  input  logic                go,
  input  logic                abort,
  input  logic [ADDR_W:0]     load_len,
  proc_run_ctrl_if.slave      bus,
  output logic                proc_start_up,
  input  logic [31:0]         pc_in,
  input  logic [31:0]         instr_in,
  input  logic [CYC_W-1:0]    max_cycles,
  output logic                running,
  output logic                done,
  output logic [1:0]          halt_reason,
  output logic [CYC_W-1:0]    cycle_count
);

  state_e                state, state_nxt;
  halt_e                 halt_q, halt_nxt;
  logic [CYC_W-1:0]      max_q;
  logic [CYC_W-1:0]      cyc_inc;
  logic [31:0]           pc_q;
  logic                  pc_valid;   // pc_q holds a value from this run's previous cycle
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  go_ok;
  logic                  ld_last;

  assign go_ok   = go && !abort && (state == ST_IDLE || state == ST_DONE);
  assign cyc_inc = (&cycle_count) ? cycle_count : cycle_count + CYC_W'(1);

  assign bus.ld_ready  = (state == ST_LOAD);
  assign running       = (state == ST_RUN);
  assign done          = (state == ST_DONE);
  assign proc_start_up = (state != ST_RUN);
  assign halt_reason   = halt_q;

  load_sequencer #(.ADDR_W(ADDR_W)) u_load (
    .clk        (clk),
    .start_up_n (start_up_n),
    .clear      (go_ok),
    .flush      (abort),
    .active     (state == ST_LOAD),
    .load_len   (load_len),
    .ld_valid   (bus.ld_valid),
    .ld_data    (bus.ld_data),
    .imem_we    (bus.imem_we),
    .imem_addr  (bus.imem_addr),
    .imem_wdata (bus.imem_wdata),
    .last       (ld_last)
  );

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_nxt = state;
    halt_nxt  = HALT_NONE;

    if (state == ST_RUN) begin
      if (instr_in == HALT_WORD)                   halt_nxt = HALT_INSTR;
      else if (pc_valid && pc_in == pc_q)          halt_nxt = HALT_PC_LOOP;
      else if (max_q != '0 && cyc_inc == max_q)    halt_nxt = HALT_BUDGET;
    end

    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: if (go) state_nxt = (load_len != '0) ? ST_LOAD : ST_HOLD;
        ST_LOAD:          if (ld_last) state_nxt = ST_HOLD;
        ST_HOLD:          if (hold_cnt == HOLD_CNT_W'(HOLD_CYC - 1)) state_nxt = ST_RUN;
        ST_RUN:           if (halt_nxt != HALT_NONE) state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      state       <= ST_IDLE;
      halt_q      <= HALT_NONE;
      cycle_count <= '0;
      max_q       <= '0;
      pc_q        <= '0;
      pc_valid    <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + HOLD_CNT_W'(1) : '0;
      pc_valid <= (state == ST_RUN);
      if (state == ST_RUN) begin
        pc_q        <= pc_in;
        cycle_count <= cyc_inc;
      end

      if (abort) begin
        halt_q <= HALT_NONE;
      end else if (go_ok) begin
        halt_q      <= HALT_NONE;
        cycle_count <= '0;
        max_q       <= max_cycles;
      end else if (state == ST_RUN && halt_nxt != HALT_NONE) begin
        halt_q <= halt_nxt;
      end
    end
  end

endmodule
